px_spi_master: RTL and testbench

//  Parametrised SPI master for the PRV32 SoC peripheral bus; successor to the fixed 8-bit SPI block.

---
 rtl/px_spi_pkg.sv | 31 +++
 rtl/px_spi_clkgen.sv | 44 ++++
 rtl/px_spi_master.sv | 216 +++++++++++++++++++++
 tb/tb_px_spi_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/px_spi_pkg.sv
// Shared types and helpers for the px_spi_master SPI master.
// Holds the FSM state encoding, SPI mode constants and width helpers.
package px_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width for a one-hot select; a single slave still needs one bit.
    function automatic int cs_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/px_spi_clkgen.sv
// Half-period tick generator: one-cycle tick every (div+1) clocks while enabled.
// The divider value is reloaded when enable rises, so each transfer uses its own div.
module px_spi_clkgen
    import px_spi_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] cnt_eff_s;
    logic             en_q;

    // Next count and tick; the first enabled cycle counts from div directly.
    always_comb begin
        cnt_eff_s = (en && !en_q) ? div : cnt_q;
        tick      = 1'b0;
        cnt_d     = cnt_q;
        if (en) begin
            tick  = (cnt_eff_s == {DIV_W{1'b0}});
            cnt_d = tick ? div : (cnt_eff_s - DIV_W'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and enable-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {DIV_W{1'b0}};
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en;
        end
    end

endmodule

// File: rtl/px_spi_master.sv
// Parametrised SPI master, all four CPOL/CPHA modes, programmable SCK divider.
// Optional LSB-first support is built when PX_SPI_LSB_FIRST_EN is defined.
module px_spi_master
    import px_spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned NCS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_W-1:0]      tx_data,
    input  logic [1:0]             mode,
    input  logic [DIV_W-1:0]       div,
    input  logic [cs_w(NCS)-1:0]   cs_sel,
`ifdef PX_SPI_LSB_FIRST_EN
    input  logic                   lsb_first,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      rx_data,
    output logic [1:0]             mode_out,
    output logic                   sck,
    output logic                   mosi,
    input  logic                   miso,
    output logic [NCS-1:0]         cs_n
);

    localparam int unsigned CS_W = cs_w(NCS);
    localparam int unsigned BC_W = clog2(DATA_W + 1);
    localparam logic [CS_W:0] NCS_L = (CS_W + 1)'(NCS);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              even_q, even_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [NCS-1:0]    cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic lsb_in_s;
    logic tick_s;
    logic clk_en_s;
    logic cs_ok_s;
    logic sample_s;
    logic last_s;

`ifdef PX_SPI_LSB_FIRST_EN
    assign lsb_in_s = lsb_first;
`else
    assign lsb_in_s = 1'b0;
`endif

    function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    assign clk_en_s = (state_q != IDLE);

    px_spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .en   (clk_en_s),
        .div  (div_q),
        .tick (tick_s)
    );

    // Next-state logic; even_q marks that the next SCK edge is an even-numbered one.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        lsb_d     = lsb_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        even_d    = even_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        cs_ok_s   = ({1'b0, cs_sel} < NCS_L);
        sample_s  = (even_q == mode_q[0]);
        last_s    = even_q && (bit_cnt_q == (mode_q[0] ? BC_W'(1) : BC_W'(0)));

        case (state_q)
            IDLE: begin
                sck_d = mode_q[1];
                if (start && cs_ok_s) begin
                    state_d   = SETUP;
                    mode_d    = mode;
                    div_d     = div;
                    lsb_d     = lsb_in_s;
                    busy_d    = 1'b1;
                    sck_d     = mode[1];
                    bit_cnt_d = BC_W'(DATA_W);
                    even_d    = 1'b0;
                    rx_sr_d   = {DATA_W{1'b0}};
                    for (int unsigned i = 0; i < NCS; i++) begin
                        cs_n_d[i] = (32'(cs_sel) != i);
                    end
                    // CPHA=0 needs the first bit on MOSI before the first (sampling) edge.
                    if (!mode[0]) begin
                        mosi_d  = out_bit(tx_data, lsb_in_s);
                        tx_sr_d = shift_out(tx_data, lsb_in_s);
                    end else begin
                        tx_sr_d = tx_data;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    state_d = SHIFT;
                end else begin
                    state_d = SETUP;
                end
            end
            SHIFT: begin
                if (tick_s) begin
                    sck_d  = ~sck_q;
                    even_d = ~even_q;
                    if (sample_s) begin
                        rx_sr_d   = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
                        bit_cnt_d = bit_cnt_q - BC_W'(1);
                    end else begin
                        mosi_d  = out_bit(tx_sr_q, lsb_q);
                        tx_sr_d = shift_out(tx_sr_q, lsb_q);
                    end
                    if (last_s) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_d   = IDLE;
                    cs_n_d    = {NCS{1'b1}};
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE0;
            div_q     <= {DIV_W{1'b0}};
            lsb_q     <= 1'b0;
            tx_sr_q   <= {DATA_W{1'b0}};
            rx_sr_q   <= {DATA_W{1'b0}};
            bit_cnt_q <= {BC_W{1'b0}};
            even_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= {NCS{1'b1}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            lsb_q     <= lsb_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            even_q    <= even_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign mode_out = mode_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_px_spi_master.sv
// Bench for px_spi_master: vector table, hand-written corner sequences, random transfers
// against a bit-indexed SPI slave model. Covers PX_SPI_LSB_FIRST_EN when defined.
module tb_px_spi_master;
    import px_spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic [7:0] div = 8'h00;
    logic [1:0] cs_sel = 2'd0;
    logic       lsb_first_tb = 1'b0;
    logic       busy, done, sck, mosi;
    logic [7:0] rx_data;
    logic [1:0] mode_out;
    logic [3:0] cs_n;
    logic       miso_w;

    logic       start_b = 1'b0;
    logic [1:0] cs_sel_b = 2'd0;
    logic       busy_b, done_b, sck_b, mosi_b;
    logic [7:0] rx_data_b;
    logic [1:0] mode_out_b;
    logic [2:0] cs_n_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    px_spi_master #(.DATA_W(8), .DIV_W(8), .NCS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .mode(mode), .div(div),
        .cs_sel(cs_sel),
`ifdef PX_SPI_LSB_FIRST_EN
        .lsb_first(lsb_first_tb),
`endif
        .busy(busy), .done(done), .rx_data(rx_data), .mode_out(mode_out), .sck(sck),
        .mosi(mosi), .miso(miso_w), .cs_n(cs_n)
    );

    // Three-slave instance so that an out-of-range select (3) is expressible.
    px_spi_master #(.DATA_W(8), .DIV_W(8), .NCS(3)) u_abort (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_data), .mode(mode), .div(div),
        .cs_sel(cs_sel_b),
`ifdef PX_SPI_LSB_FIRST_EN
        .lsb_first(lsb_first_tb),
`endif
        .busy(busy_b), .done(done_b), .rx_data(rx_data_b), .mode_out(mode_out_b), .sck(sck_b),
        .mosi(mosi_b), .miso(mosi_b), .cs_n(cs_n_b)
    );

    // Slave model: addresses bits by time index rather than shifting.
    logic       lpbk = 1'b0;
    logic [1:0] sl_mode = 2'b00;
    logic       sl_lsb = 1'b0;
    logic [7:0] sl_tx = 8'h00;
    logic [7:0] sl_rx = 8'h00;
    logic       sl_miso = 1'b0;
    int         sl_edges = 0;
    int         sl_ns = 0;
    int         cs_falls = 0;
    time        cs_fall_t = 0;
    logic       cs_act_n;

    assign cs_act_n = &cs_n;
    assign miso_w   = lpbk ? mosi : sl_miso;

    function automatic logic word_bit(input logic [7:0] w, input int k, input logic lsb);
        return lsb ? w[k] : w[7-k];
    endfunction

    always @(negedge cs_act_n) begin
        cs_falls++;
        cs_fall_t = $time;
        sl_edges  = 0;
        sl_ns     = 0;
        sl_rx     = 8'h00;
        if (!sl_mode[0]) sl_miso = word_bit(sl_tx, 0, sl_lsb);
    end

    always @(sck) begin
        #1;
        if (!cs_act_n && ($time - 1) != cs_fall_t) begin
            sl_edges++;
            if (((sl_edges % 2) == 1) == (sl_mode[0] == 1'b0)) begin
                if (sl_ns < 8) sl_rx[sl_lsb ? sl_ns : 7 - sl_ns] = mosi;
                sl_ns++;
            end else if (sl_ns < 8) begin
                sl_miso = word_bit(sl_tx, sl_ns, sl_lsb);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] dv;
        logic [1:0] cs;
        logic [7:0] tx;
        logic [7:0] reply;
        logic       lp;
        logic       lsb;
        logic [7:0] exp_rx;
        logic [7:0] exp_sl;
        int         exp_cyc;
    } vec_t;

    task automatic do_vec(input vec_t v, input string tag);
        int cyc, cs_err, falls0;
        logic first_bit, got_done;
        logic [3:0] exp_cs;
        exp_cs = ~(4'b0001 << v.cs);
        @(negedge clk);
        mode = v.mode; div = v.dv; cs_sel = v.cs; tx_data = v.tx; lsb_first_tb = v.lsb;
        sl_mode = v.mode; sl_lsb = v.lsb; sl_tx = v.reply; lpbk = v.lp;
        falls0 = cs_falls;
        start = 1'b1;
        cyc = 0; cs_err = 0; got_done = 1'b0; first_bit = 1'b0;
        while (!got_done && cyc < v.exp_cyc + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                first_bit = mosi;
            end
            if (busy && cs_n !== exp_cs) cs_err++;
            if (done) got_done = 1'b1;
        end
        check({tag, " cycles"}, cyc, v.exp_cyc);
        check({tag, " done_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, " rx_data"}, {24'd0, rx_data}, {24'd0, v.exp_rx});
        check({tag, " slave_rx"}, {24'd0, sl_rx}, {24'd0, v.exp_sl});
        check({tag, " cs_during"}, cs_err, 0);
        check({tag, " cs_falls"}, cs_falls - falls0, 1);
        check({tag, " cs_after"}, {28'd0, cs_n}, 32'hF);
        check({tag, " sck_idle"}, {31'd0, sck}, {31'd0, v.mode[1]});
        check({tag, " mode_out"}, {30'd0, mode_out}, {30'd0, v.mode});
        if (!v.mode[0]) check({tag, " first_mosi"}, {31'd0, first_bit},
                              {31'd0, (v.lsb ? v.tx[0] : v.tx[7])});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int first, second, dn, overlap, c, toggles, cnt_busy, cnt_done, cnt_cs;
        logic prev;

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst rx_data", {24'd0, rx_data}, 32'd0);
        check("rst mode_out", {30'd0, mode_out}, 32'd0);
        check("rst sck_mosi", {30'd0, sck, mosi}, 32'd0);
        check("rst cs_n", {28'd0, cs_n}, 32'hF);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{MODE0, 8'd1, 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5, 37});
        tbl.push_back('{MODE1, 8'd1, 2'd0, 8'hC3, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'hC3, 37});
        tbl.push_back('{MODE2, 8'd1, 2'd0, 8'hC3, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'hC3, 37});
        tbl.push_back('{MODE3, 8'd1, 2'd0, 8'hC3, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'hC3, 37});
        tbl.push_back('{MODE0, 8'd2, 2'd2, 8'h5A, 8'hE1, 1'b0, 1'b0, 8'hE1, 8'h5A, 55});
        tbl.push_back('{MODE3, 8'd0, 2'd3, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 19});
`ifdef PX_SPI_LSB_FIRST_EN
        tbl.push_back('{MODE0, 8'd1, 2'd0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h01, 8'h01, 37});
        tbl.push_back('{MODE1, 8'd1, 2'd1, 8'hB4, 8'h2D, 1'b0, 1'b1, 8'h2D, 8'hB4, 37});
`endif
        foreach (tbl[i]) do_vec(tbl[i], $sformatf("vec%0d", i));

        // start held high across a whole transfer; div changed mid-transfer.
        @(negedge clk);
        mode = MODE0; div = 8'd1; cs_sel = 2'd0; tx_data = 8'h5A; lpbk = 1'b1; sl_mode = MODE0;
        start = 1'b1;
        first = 0; second = 0; dn = 0; overlap = 0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            if (k == 2) div = 8'd0;
            if (done) begin
                dn++;
                if (busy) overlap++;
                if (dn == 1) first = k;
                else if (dn == 2) second = k;
            end
            if (dn == 1 && k == first + 1) begin
                check("hold re-accept busy", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
        end
        check("hold first_done", first, 37);
        check("hold second_len", second - first, 19);
        check("hold done_count", dn, 2);
        check("hold overlap", overlap, 0);
        check("hold rx_data", {24'd0, rx_data}, 32'h5A);

        // Out-of-range select on the three-slave instance, then an in-range one.
        @(negedge clk);
        mode = MODE0; div = 8'd1; tx_data = 8'h6B; cs_sel_b = 2'd3; start_b = 1'b1;
        cnt_busy = 0; cnt_done = 0; cnt_cs = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) start_b = 1'b0;
            if (busy_b) cnt_busy++;
            if (done_b) cnt_done++;
            if (cs_n_b !== 3'b111) cnt_cs++;
        end
        check("abort busy", cnt_busy, 0);
        check("abort done", cnt_done, 0);
        check("abort cs_n", cnt_cs, 0);
        @(negedge clk);
        cs_sel_b = 2'd2; start_b = 1'b1;
        c = 0; cnt_cs = 0; cnt_done = 0;
        while (cnt_done == 0 && c < 80) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) start_b = 1'b0;
            if (busy_b && cs_n_b !== 3'b011) cnt_cs++;
            if (done_b) cnt_done++;
        end
        check("sel2 cycles", c, 37);
        check("sel2 cs_n", cnt_cs, 0);
        check("sel2 rx_data", {24'd0, rx_data_b}, 32'h6B);

        // Random transfers against the reference rules.
        for (int r = 0; r < 24; r++) begin
            v.mode  = 2'($urandom_range(0, 3));
            v.dv    = 8'($urandom_range(0, 4));
            v.cs    = 2'($urandom_range(0, 3));
            v.tx    = 8'($urandom);
            v.reply = 8'($urandom);
            v.lp    = 1'($urandom_range(0, 1));
`ifdef PX_SPI_LSB_FIRST_EN
            v.lsb   = 1'($urandom_range(0, 1));
`else
            v.lsb   = 1'b0;
`endif
            v.exp_rx  = v.lp ? v.tx : v.reply;
            v.exp_sl  = v.tx;
            v.exp_cyc = 1 + (2 * 8 + 2) * (int'(v.dv) + 1);
            do_vec(v, $sformatf("rnd%0d", r));
        end

        // Reset at the seventh SCK edge of a CPOL=1 transfer.
        @(negedge clk);
        mode = MODE2; div = 8'd1; cs_sel = 2'd1; tx_data = 8'h96; lpbk = 1'b1; sl_mode = MODE2;
        start = 1'b1;
        c = 0; toggles = 0; prev = sck;
        while (toggles < 7 && c < 200) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) begin
                start = 1'b0;
                prev = sck;
            end else if (sck !== prev) begin
                toggles++;
                prev = sck;
            end
        end
        check("rstmid edges", toggles, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid cs_n", {28'd0, cs_n}, 32'hF);
        check("rstmid busy", {31'd0, busy}, 32'd0);
        check("rstmid sck", {31'd0, sck}, 32'd0);
        check("rstmid rx_data", {24'd0, rx_data}, 32'd0);
        cnt_done = done ? 1 : 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done) cnt_done++;
        end
        check("rstmid no_done", cnt_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
